ram_arbiter: RTL and testbench

- Shares the single-port 1024x16 program/data RAM between two requesters: master 0 (CPU core memory port) and master 1 (DMA/loader engine).
- Makes a per-cycle round-robin grant, with optional master-1 burst lock bounded by a starvation limit.
- Muxes the winner onto the RAM port and routes synchronous read data back to the owner one cycle later.
- Sits between cpu/dma and ram.

---
 rtl/ram_arb_pkg.sv | 14 +
 rtl/ram_arbiter_rr_arb2.sv | 21 ++
 rtl/ram_arbiter.sv | 109 ++++++++++
 tb/tb_ram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the program/data RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_LOCK = 8;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-input round-robin picker; lock_hold lets master 1 keep a won tie.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    input  logic       lock_hold,
    output owner_t     winner
);

    always_comb begin
        winner = OWN_NONE;
        case (req)
            2'b01:   winner = OWN_M0;
            2'b10:   winner = OWN_M1;
            2'b11:   winner = (lock_hold || last_owner == OWN_M0) ? OWN_M1 : OWN_M0;
            default: winner = OWN_NONE;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous single-port RAM between the CPU (m0) and DMA (m1),
// returning read data to whichever master issued the read one cycle earlier.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_LOCK = DEF_MAX_LOCK
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_din,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_din,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_dout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [7:0] LOCK_LIM = 8'(MAX_LOCK);

    owner_t            last_owner;
    owner_t            rd_owner;
    owner_t            winner;
    logic [7:0]        lock_cnt;
    logic              lock_prev;
    logic              lock_hold;
    logic [1:0]        req;
    logic [DATA_W-1:0] m0_hold;
    logic [DATA_W-1:0] m1_hold;

    // Requests are masked by reset so nothing is granted while rst_n is low.
    assign req       = {m1_req & rst_n, m0_req & rst_n};
    assign lock_hold = (last_owner == OWN_M1) && lock_prev && (lock_cnt < LOCK_LIM);

    rr_arb2 u_pick (
        .req        (req),
        .last_owner (last_owner),
        .lock_hold  (lock_hold),
        .winner     (winner)
    );

    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        ram_addr  = '0;
        ram_write = 1'b0;
        ram_din   = '0;
        case (winner)
            OWN_M0: begin
                m0_gnt    = 1'b1;
                ram_addr  = m0_addr;
                ram_write = m0_write;
                ram_din   = m0_din;
            end
            OWN_M1: begin
                m1_gnt    = 1'b1;
                ram_addr  = m1_addr;
                ram_write = m1_write;
                ram_din   = m1_din;
            end
            default: ;
        endcase
    end

    // lock_cnt only counts master-1 wins that kept a waiting master 0 out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWN_M1;
            rd_owner   <= OWN_NONE;
            lock_cnt   <= '0;
            lock_prev  <= 1'b0;
            m0_hold    <= '0;
            m1_hold    <= '0;
        end else begin
            if (winner != OWN_NONE)
                last_owner <= winner;
            if (winner == OWN_M1 && m0_req)
                lock_cnt <= (lock_cnt >= LOCK_LIM) ? LOCK_LIM : lock_cnt + 8'd1;
            else
                lock_cnt <= '0;
            lock_prev <= (winner == OWN_M1) && m1_lock;
            rd_owner  <= (winner != OWN_NONE && !ram_write) ? winner : OWN_NONE;
            if (rd_owner == OWN_M0)
                m0_hold <= ram_dout;
            if (rd_owner == OWN_M1)
                m1_hold <= ram_dout;
        end
    end

    assign m0_rvalid = (rd_owner == OWN_M0);
    assign m1_rvalid = (rd_owner == OWN_M1);
    assign m0_dout   = m0_rvalid ? ram_dout : m0_hold;
    assign m1_dout   = m1_rvalid ? ram_dout : m1_hold;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ram_arbiter;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 16;
    localparam int MAX_LOCK = 8;

    logic              clk;
    logic              rst_n;
    logic              m0_req, m0_write, m0_gnt, m0_rvalid;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_din, m0_dout;
    logic              m1_req, m1_write, m1_lock, m1_gnt, m1_rvalid;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_din, m1_dout;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_write;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_dout(m1_dout),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [9:0] a);
        if (a == 10'h005)
            return 16'hBEEF;
        return {a[5:0], a} ^ 16'h1357;
    endfunction

    // Synchronous RAM, write-first, contents start from init_val().
    logic [15:0] mem [1024];
    bit          mem_seen [1024];
    initial ram_dout = '0;
    always @(posedge clk) begin
        if (ram_write) begin
            mem[ram_addr]      <= ram_din;
            mem_seen[ram_addr] <= 1'b1;
            ram_dout           <= ram_din;
        end else begin
            ram_dout <= mem_seen[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the RAM, how long m1 has kept m0 out, and
    // what each master should have seen returned.
    int          mdl_last;
    int          mdl_streak;
    bit          mdl_lockprev;
    bit          exp_rv0, exp_rv1;
    logic [15:0] exp_d0, exp_d1;
    bit          g0_last, g1_last;
    logic [15:0] shadow [1024];
    bit          sh_seen [1024];

    function automatic int mdl_pick(input bit r0, input bit r1);
        if (!r0 && !r1) return -1;
        if (r0 && !r1)  return 0;
        if (!r0 && r1)  return 1;
        if (mdl_last == 1 && mdl_lockprev && mdl_streak < MAX_LOCK) return 1;
        return 1 - mdl_last;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            mdl_last     <= 1;
            mdl_streak   <= 0;
            mdl_lockprev <= 1'b0;
            exp_rv0      <= 1'b0;
            exp_rv1      <= 1'b0;
            exp_d0       <= '0;
            exp_d1       <= '0;
            g0_last      <= 1'b0;
            g1_last      <= 1'b0;
        end else begin
            w = mdl_pick(m0_req, m1_req);
            exp_rv0 <= (w == 0) && !m0_write;
            exp_rv1 <= (w == 1) && !m1_write;
            if (w == 0 && !m0_write) exp_d0 <= sh_seen[m0_addr] ? shadow[m0_addr] : init_val(m0_addr);
            if (w == 1 && !m1_write) exp_d1 <= sh_seen[m1_addr] ? shadow[m1_addr] : init_val(m1_addr);
            if (w == 0 && m0_write) begin
                shadow[m0_addr]  <= m0_din;
                sh_seen[m0_addr] <= 1'b1;
            end
            if (w == 1 && m1_write) begin
                shadow[m1_addr]  <= m1_din;
                sh_seen[m1_addr] <= 1'b1;
            end
            if (w >= 0) mdl_last <= w;
            mdl_streak   <= (w == 1 && m0_req) ? ((mdl_streak + 1 > MAX_LOCK) ? MAX_LOCK : mdl_streak + 1) : 0;
            mdl_lockprev <= (w == 1) && m1_lock;
            g0_last      <= (w == 0);
            g1_last      <= (w == 1);
        end
    end

    // Compare every output against the model on each falling edge.
    int m0_wait = 0;
    always @(negedge clk) begin
        int          w;
        logic [9:0]  ea;
        logic [15:0] ed;
        bit          ew;
        w  = mdl_pick(m0_req && rst_n, m1_req && rst_n);
        ea = (w == 0) ? m0_addr : (w == 1) ? m1_addr : '0;
        ed = (w == 0) ? m0_din  : (w == 1) ? m1_din  : '0;
        ew = (w == 0) ? m0_write : (w == 1) ? m1_write : 1'b0;
        checkOutput("m0_gnt",    m0_gnt,    w == 0);
        checkOutput("m1_gnt",    m1_gnt,    w == 1);
        checkOutput("ram_addr",  ram_addr,  ea);
        checkOutput("ram_write", ram_write, ew);
        checkOutput("ram_din",   ram_din,   ed);
        checkOutput("m0_rvalid", m0_rvalid, exp_rv0);
        checkOutput("m1_rvalid", m1_rvalid, exp_rv1);
        checkOutput("m0_dout",   m0_dout,   exp_d0);
        checkOutput("m1_dout",   m1_dout,   exp_d1);
        if (m0_req && rst_n) begin
            if (m0_gnt) begin
                checkOutput("m0_starve", (m0_wait <= MAX_LOCK), 1);
                m0_wait = 0;
            end else begin
                m0_wait++;
            end
        end else begin
            m0_wait = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit r0, input bit w0, input logic [9:0] a0, input logic [15:0] d0,
                                 input bit r1, input bit w1, input logic [9:0] a1, input logic [15:0] d1,
                                 input bit lk);
        m0_req = r0; m0_write = w0; m0_addr = a0; m0_din = d0;
        m1_req = r1; m1_write = w1; m1_addr = a1; m1_din = d1; m1_lock = lk;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] a0, a1;
        int         burst;
        bit         done;
        rst_n = 1'b0;
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
        repeat (3) tick();
        checkOutput("rst_m0_dout",  m0_dout,   16'h0);
        checkOutput("rst_ram_addr", ram_addr,  10'h0);
        checkOutput("rst_m0_rv",    m0_rvalid, 1'b0);
        rst_n = 1'b1;

        $display("[TB] m0 single read");
        tick();
        applyStimulus(1, 0, 10'h005, '0, 0, 0, '0, '0, 0);
        #1;
        checkOutput("t1_gnt",  m0_gnt,   1'b1);
        checkOutput("t1_addr", ram_addr, 10'h005);
        tick();
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
        #1;
        checkOutput("t1_rvalid",  m0_rvalid, 1'b1);
        checkOutput("t1_dout",    m0_dout,   16'hBEEF);
        checkOutput("t1_m1_rv",   m1_rvalid, 1'b0);

        $display("[TB] alternating reads");
        doReset();
        a0 = 10'h100;
        a1 = 10'h200;
        tick();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, a0, '0, 1, 0, a1, '0, 0);
            #1;
            checkOutput("t2_m0_gnt", m0_gnt, (i % 2) == 0);
            checkOutput("t2_m1_gnt", m1_gnt, (i % 2) == 1);
            if (m0_gnt) a0 = a0 + 10'd1;
            if (m1_gnt) a1 = a1 + 10'd1;
            tick();
        end

        $display("[TB] m1 locked burst");
        applyStimulus(0, 0, '0, '0, 1, 1, 10'h3FF, 16'h1234, 1);
        #1;
        checkOutput("t3_first", m1_gnt, 1'b1);
        tick();
        burst = 0;
        done  = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            applyStimulus(1, 0, 10'h3FF, '0, 1, 1, 10'h3FF, 16'h1234, 1);
            #1;
            if (m0_gnt) done = 1'b1;
            else if (m1_gnt) burst++;
            tick();
        end
        checkOutput("t3_m0_won", done, 1'b1);
        checkOutput("t3_burst",  burst, MAX_LOCK);
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
        #1;
        checkOutput("t3_rvalid", m0_rvalid, 1'b1);
        checkOutput("t3_dout",   m0_dout,   16'h1234);

        $display("[TB] write then read");
        tick();
        applyStimulus(0, 0, '0, '0, 1, 1, 10'h010, 16'hA5A5, 0);
        #1;
        checkOutput("t4_wgnt", m1_gnt,    1'b1);
        checkOutput("t4_we",   ram_write, 1'b1);
        tick();
        applyStimulus(1, 0, 10'h010, '0, 0, 0, '0, '0, 0);
        #1;
        checkOutput("t4_rgnt",   m0_gnt,    1'b1);
        checkOutput("t4_norv",   m1_rvalid, 1'b0);
        tick();
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
        #1;
        checkOutput("t4_rvalid", m0_rvalid, 1'b1);
        checkOutput("t4_dout",   m0_dout,   16'hA5A5);

        $display("[TB] reset during read return");
        tick();
        applyStimulus(1, 0, 10'h005, '0, 0, 0, '0, '0, 0);
        #1;
        checkOutput("t5_gnt", m0_gnt, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
        #2;
        checkOutput("t5_rv_rst",   m0_rvalid, 1'b0);
        checkOutput("t5_dout_rst", m0_dout,   16'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        #1;
        checkOutput("t5_rv_after", m0_rvalid, 1'b0);
        checkOutput("t5_addr",     ram_addr,  10'h0);

        $display("[TB] idle keeps last owner");
        applyStimulus(1, 0, 10'h020, '0, 0, 0, '0, '0, 0);
        tick();
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            checkOutput("t6_we",   ram_write, 1'b0);
            checkOutput("t6_addr", ram_addr,  10'h0);
        end
        tick();
        applyStimulus(1, 0, 10'h030, '0, 1, 0, 10'h031, '0, 0);
        #1;
        checkOutput("t6_tie_m1", m1_gnt, 1'b1);
        checkOutput("t6_tie_m0", m0_gnt, 1'b0);
        tick();
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!(m0_req && !g0_last)) begin
                m0_req   = ($urandom_range(0, 9) < 6);
                m0_write = ($urandom_range(0, 9) < 3);
                m0_addr  = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 31)) : 10'($urandom);
                m0_din   = 16'($urandom);
            end
            if (!(m1_req && !g1_last)) begin
                m1_req   = ($urandom_range(0, 9) < 6);
                m1_write = ($urandom_range(0, 9) < 3);
                m1_addr  = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 31)) : 10'($urandom);
                m1_din   = 16'($urandom);
                m1_lock  = ($urandom_range(0, 1) == 1);
            end
        end
        tick();
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
